// File: rtl/scmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state encoding
// and the one-hot result record carried by the controller.
package scmp_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } scmp_result_t;

  localparam scmp_result_t RES_NONE = '{gt: 1'b0, eq: 1'b0, lt: 1'b0};
  localparam scmp_result_t RES_GT   = '{gt: 1'b1, eq: 1'b0, lt: 1'b0};
  localparam scmp_result_t RES_EQ   = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
  localparam scmp_result_t RES_LT   = '{gt: 1'b0, eq: 1'b0, lt: 1'b1};

  // Index register width; a 1-bit operand still needs a 1-bit index.
  function automatic int unsigned scmp_idx_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_mag_comparator_ctrl_comparator1bit.sv
// Single-bit magnitude comparator: o1 = A>B, o2 = A==B, o3 = A<B.
// Purely combinational; exactly one output is high for any input pair.
module comparator1bit (
  input  logic A,
  input  logic B,
  output logic o1,
  output logic o2,
  output logic o3
);

  assign o1 = A & ~B;
  assign o2 = ~(A ^ B);
  assign o3 = ~A & B;

endmodule

// File: rtl/serial_mag_comparator_ctrl.sv
// Serial MSB-first magnitude comparator controller: captures operands on start,
// walks one bit per clock through a single comparator1bit, exits on first difference.
module serial_mag_comparator_ctrl
  import scmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int IW = scmp_idx_width(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  scmp_result_t     res_q, res_d;

  logic bit_a, bit_b;
  logic bit_gt, bit_eq, bit_lt;

  assign bit_a = a_q[idx_q];
  assign bit_b = b_q[idx_q];

  comparator1bit u_cmp (
    .A  (bit_a),
    .B  (bit_b),
    .o1 (bit_gt),
    .o2 (bit_eq),
    .o3 (bit_lt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_MSB;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        // First differing bit decides; equality only resolves at bit 0.
        if (bit_gt) begin
          res_d   = RES_GT;
          state_d = ST_DONE;
        end else if (bit_lt) begin
          res_d   = RES_LT;
          state_d = ST_DONE;
        end else if (bit_eq && (idx_q == '0)) begin
          res_d   = RES_EQ;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      res_q   <= RES_NONE;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q == ST_COMPARE);
  assign done   = (state_q == ST_DONE);
  assign a_gt_b = res_q.gt;
  assign a_eq_b = res_q.eq;
  assign a_lt_b = res_q.lt;

endmodule

// File: tb/tb_serial_mag_comparator_ctrl.sv
// Directed bench for serial_mag_comparator_ctrl (WIDTH=8): checks reset,
// latency, early exit, ignored starts, and async abort with immediate assertions.
module tb_serial_mag_comparator_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       a_gt_b;
  logic       a_eq_b;
  logic       a_lt_b;

  int n_assert = 0;
  int n_fail   = 0;

  serial_mag_comparator_ctrl #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .a_gt_b (a_gt_b),
    .a_eq_b (a_eq_b),
    .a_lt_b (a_lt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_res"}, 32'({a_gt_b, a_eq_b, a_lt_b}), 0);
  endtask

  // Starts a compare from IDLE, scrambles a/b after capture, and checks
  // k COMPARE cycles, the done pulse in cycle k+1, and held results in k+2.
  task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input int k, input logic [2:0] exp_res);
    start = 1'b1;
    a     = av;
    b     = bv;
    step();
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    for (int i = 1; i <= k; i++) begin
      chk($sformatf("%s_busy_c%0d", tag, i), 32'(busy), 1);
      chk($sformatf("%s_nodone_c%0d", tag, i), 32'(done), 0);
      step();
    end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy_in_done"}, 32'(busy), 0);
    chk({tag, "_res"}, 32'({a_gt_b, a_eq_b, a_lt_b}), 32'(exp_res));
    step();
    chk({tag, "_done_pulse_end"}, 32'(done), 0);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_res_held"}, 32'({a_gt_b, a_eq_b, a_lt_b}), 32'(exp_res));
    $display("txn %s a=%02h b=%02h k=%0d res(gt,eq,lt)=%03b", tag, av, bv, k, exp_res);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'($urandom);
    b     = 8'($urandom);
    #1;
    chk_all_zero("reset_t0");
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      step();
      chk_all_zero($sformatf("reset_c%0d", i));
    end
    start = 1'b0;
    rst_n = 1'b1;
    step();
    chk_all_zero("post_reset_idle");
    $display("txn reset held with start=1: outputs zero");

    run_cmp("gt_msb", 8'h80, 8'h7F, 1, 3'b100);
    run_cmp("lt_lsb", 8'h12, 8'h13, 8, 3'b001);
    run_cmp("eq_a5", 8'hA5, 8'hA5, 8, 3'b010);

    // start held through COMPARE and DONE must not queue a new compare
    start = 1'b1;
    a     = 8'h80;
    b     = 8'h7F;
    step();
    a = 8'h00;
    b = 8'hFF;
    chk("ign_busy_c1", 32'(busy), 1);
    step();
    chk("ign_done_c2", 32'(done), 1);
    chk("ign_res_c2", 32'({a_gt_b, a_eq_b, a_lt_b}), 32'h4);
    step();
    start = 1'b0;
    chk("ign_idle_busy_c3", 32'(busy), 0);
    chk("ign_idle_done_c3", 32'(done), 0);
    chk("ign_res_c3", 32'({a_gt_b, a_eq_b, a_lt_b}), 32'h4);
    $display("txn ignored start during COMPARE/DONE: result gt kept");
    step();
    chk("ign_still_idle", 32'(busy), 0);
    run_cmp("after_ignore", 8'h00, 8'hFF, 1, 3'b001);

    // async abort in cycle 4 of an 8-cycle equal compare
    start = 1'b1;
    a     = 8'h3C;
    b     = 8'h3C;
    step();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("abort_busy_c%0d", i), 32'(busy), 1);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort_immediate");
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all_zero($sformatf("abort_hold_c%0d", i));
    end
    rst_n = 1'b1;
    step();
    chk_all_zero("abort_release");
    $display("txn abort of a=b=3C in cycle 4: outputs zero, no done");

    run_cmp("gt_lsb", 8'h01, 8'h00, 8, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end, expected finish");
    $fatal(1, "timeout");
  end

endmodule
